// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
// Settings records are sized for the widest ratio so every channel width shares one type.
package clk_div_pkg;

  localparam int W_DEF     = 8;
  localparam int MAX_W     = 16;
  localparam int MIN_RATIO = 2;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } ch_state_e;

  typedef struct packed {
    logic [MAX_W-1:0] n;
    logic [MAX_W-1:0] h;
  } settings_t;

  // Ratios below the minimum would give a degenerate one-cycle clock.
  function automatic logic [MAX_W-1:0] eff_period(input logic [MAX_W-1:0] n);
    return (n < MAX_W'(MIN_RATIO)) ? MAX_W'(MIN_RATIO) : n;
  endfunction

endpackage

// File: rtl/clk_div_if.sv
// Control/status bundle for all divider channels; fields packed per channel at [c*W +: W].
interface clk_div_if #(
  parameter int CH = 4,
  parameter int W  = 8
);
  logic [CH-1:0]   en;
  logic [CH-1:0]   load;
  logic [CH*W-1:0] div;
  logic [CH*W-1:0] hi;
  logic [CH-1:0]   clk_out;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   pend;

  modport master (output en, load, div, hi, input clk_out, tick, pend);
  modport slave  (input en, load, div, hi, output clk_out, tick, pend);
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: active/shadow settings, period counter, registered clock and tick.
// New settings only take effect at a period boundary, so no runt periods are produced.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en_i,
  input  logic      load_i,
  input  settings_t cfg_i,
  output logic      clk_out_o,
  output logic      tick_o,
  output logic      pend_o
);

  ch_state_e    state_q, state_d;
  settings_t    act_q, act_d;
  settings_t    shd_q, shd_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         pend_q, pend_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;
  logic         wrap, restart, apply;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      act_q   <= '0;
      shd_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (en_i)  state_d = ST_RUN;
      ST_RUN:  if (!en_i) state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase

    wrap    = (state_q == ST_RUN) &&
              (MAX_W'(cnt_q) == eff_period(act_q.n) - MAX_W'(1));
    // Disable, first enabled cycle and wrap are all period boundaries.
    restart = !en_i || (state_q != ST_RUN) || wrap;
    apply   = pend_q && restart;

    act_d   = apply ? shd_q : act_q;
    shd_d   = load_i ? cfg_i : shd_q;
    pend_d  = load_i || (pend_q && !apply);
    cnt_d   = restart ? '0 : cnt_q + W'(1);

    // Outputs are computed from next-state so they line up with the visible count.
    tick_d  = en_i && (cnt_d == '0);
    clk_d   = en_i && (MAX_W'(cnt_d) < act_d.h);
  end

  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;
  assign pend_o    = pend_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: slices the packed bus into per-channel settings.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CH = 4,
  parameter int W  = W_DEF
) (
  input logic     clk,
  input logic     rst_n,
  clk_div_if.slave bus
);

  logic [CH-1:0] clk_out_w;
  logic [CH-1:0] tick_w;
  logic [CH-1:0] pend_w;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    settings_t cfg;
    assign cfg.n = MAX_W'(bus.div[g*W +: W]);
    assign cfg.h = MAX_W'(bus.hi[g*W +: W]);

    clk_div_ch #(.W(W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (bus.en[g]),
      .load_i   (bus.load[g]),
      .cfg_i    (cfg),
      .clk_out_o(clk_out_w[g]),
      .tick_o   (tick_w[g]),
      .pend_o   (pend_w[g])
    );
  end

  assign bus.clk_out = clk_out_w;
  assign bus.tick    = tick_w;
  assign bus.pend    = pend_w;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: channel-0 vector table, reset/en corner sequences, four-channel run.
module tb_clk_div_prog;
  localparam int CH = 4;
  localparam int W  = 8;

  typedef struct {
    logic       en;
    logic       ld;
    logic [W-1:0] n;
    logic [W-1:0] h;
    logic       ec;
    logic       et;
    logic       ep;
  } vec_t;

  typedef struct {
    logic [CH-1:0] c;
    logic [CH-1:0] t;
    logic [CH-1:0] p;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t tbl[$];
  exp_t sbq[$];

  clk_div_if #(.CH(CH), .W(W)) bus ();

  clk_div_prog #(.CH(CH), .W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic add(input int rep, input logic en, input logic ld, input int n, input int h,
                     input logic c, input logic t, input logic p);
    vec_t v;
    v.en = en; v.ld = ld; v.n = W'(n); v.h = W'(h); v.ec = c; v.et = t; v.ep = p;
    for (int r = 0; r < rep; r++) tbl.push_back(v);
  endtask

  task automatic drive0(input logic en, input logic ld, input logic [W-1:0] n,
                        input logic [W-1:0] h);
    bus.en   = '0;
    bus.load = '0;
    bus.div  = '0;
    bus.hi   = '0;
    bus.en[0]       = en;
    bus.load[0]     = ld;
    bus.div[W-1:0]  = n;
    bus.hi[W-1:0]   = h;
  endtask

  task automatic push0(input logic c, input logic t, input logic p);
    exp_t e;
    e.c = '0; e.t = '0; e.p = '0;
    e.c[0] = c; e.t[0] = t; e.p[0] = p;
    sbq.push_back(e);
  endtask

  task automatic compare(input string name);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got clk_out=%b tick=%b pend=%b",
               name, bus.clk_out, bus.tick, bus.pend);
    end else begin
      e = sbq.pop_front();
      if (bus.clk_out !== e.c || bus.tick !== e.t || bus.pend !== e.p) begin
        errors++;
        $display("FAIL %s: got clk_out=%b tick=%b pend=%b, expected clk_out=%b tick=%b pend=%b",
                 name, bus.clk_out, bus.tick, bus.pend, e.c, e.t, e.p);
      end
    end
  endtask

  task automatic check_next(input string name);
    @(posedge clk);
    #1;
    compare(name);
  endtask

  int   nv[CH] = '{3, 4, 5, 7};
  int   hv[CH] = '{1, 2, 1, 3};

  initial begin
    exp_t e;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive0(1'b0, 1'b0, '0, '0);

    // case 1: N=4 H=2
    add(1, 0, 1, 4, 2, 0, 0, 1);
    add(1, 1, 0, 0, 0, 1, 1, 0);
    add(1, 1, 0, 0, 0, 1, 0, 0);
    add(2, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 1, 0);
    add(1, 1, 0, 0, 0, 1, 0, 0);
    // case 2: load N=6 H=3 at cnt=1, applied at wrap
    add(1, 1, 1, 6, 3, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 1, 1, 0);
    add(2, 1, 0, 0, 0, 1, 0, 0);
    add(3, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 1, 0);
    // case 3: N=1 H=1 -> period 2; N=5 H=0 -> low; N=5 H=7 -> high
    add(1, 1, 1, 1, 1, 1, 0, 1);
    add(1, 1, 0, 0, 0, 1, 0, 1);
    add(3, 1, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 1, 1, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 1, 0);
    add(1, 1, 1, 5, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(4, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(1, 1, 1, 5, 7, 0, 0, 1);
    add(3, 1, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 1, 1, 0);
    add(4, 1, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 1, 0);
    // case 4: shadow 3/1 pending, load 4/3 in the wrap cycle
    add(1, 1, 1, 3, 1, 1, 0, 1);
    add(3, 1, 0, 0, 0, 1, 0, 1);
    add(1, 1, 1, 4, 3, 1, 1, 1);
    add(2, 1, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 1, 1, 0);
    add(2, 1, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 1, 0);
    // case 5: en drop mid-period, load while disabled
    add(1, 1, 0, 0, 0, 1, 0, 0);
    add(2, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 1, 0);
    add(1, 1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 1, 2, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 1, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    push0(0, 0, 0);
    compare("reset_state");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive0(tbl[i].en, tbl[i].ld, tbl[i].n, tbl[i].h);
      push0(tbl[i].ec, tbl[i].et, tbl[i].ep);
      check_next($sformatf("vec%0d", i));
    end

    // reset mid-period with a pending load: pending discarded, restart from cnt=0
    drive0(1'b1, 1'b1, 8'd9, 8'd4);
    push0(0, 0, 1);
    check_next("rst_preload");
    drive0(1'b1, 1'b0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    push0(0, 0, 0);
    compare("rst_async");
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    push0(0, 1, 0);
    check_next("rst_restart");
    push0(0, 0, 0);
    check_next("rst_cnt1");
    push0(0, 1, 0);
    check_next("rst_wrap");

    // four channels with distinct ratios
    bus.en   = '0;
    bus.load = '1;
    for (int c = 0; c < CH; c++) begin
      bus.div[c*W +: W] = W'(nv[c]);
      bus.hi[c*W +: W]  = W'(hv[c]);
    end
    e.c = '0; e.t = '0; e.p = '1;
    sbq.push_back(e);
    check_next("multi_load");
    bus.en   = '1;
    bus.load = '0;
    for (int k = 0; k < 84; k++) begin
      for (int c = 0; c < CH; c++) begin
        e.c[c] = ((k % nv[c]) < hv[c]);
        e.t[c] = ((k % nv[c]) == 0);
      end
      e.p = '0;
      sbq.push_back(e);
      check_next($sformatf("multi_k%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter CH, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter W, default 8: width of the per-channel ratio and high-time fields, 2..16.
REQ-003 Port clk, input, 1: single clock for all logic. The clock is one clock; reset is asynchronous and active-low.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset, released synchronously to clk.
REQ-005 Port en, input, CH: per-channel run enable.
REQ-006 Port load, input, CH: per-channel single-cycle request to capture new settings.
REQ-007 Port div, input, CH*W: per-channel period N in clk cycles; channel c uses bits [c*W +: W].
REQ-008 Port hi, input, CH*W: per-channel high time H in clk cycles; same packing as div.
REQ-009 Port clk_out, output, CH: registered divided clock per channel.
REQ-010 Port tick, output, CH: one-cycle pulse marking the first cycle of each period.
REQ-011 Port pend, output, CH: high while captured settings wait to be applied.

Function
REQ-012 Each channel SHALL hold an active set (N_a, H_a), a shadow set (N_s, H_s), a W-bit counter cnt, and a pending flag.
REQ-013 load[c]=1 SHALL copy div/hi into the shadow set and set pend[c] on the next edge; a load while pend is set SHALL overwrite the shadow set (last wins).
REQ-014 The effective period SHALL be max(N_a,2); N_a of 0 or 1 SHALL be treated as 2.
REQ-015 While en[c]=1, cnt SHALL increment by 1 each cycle and wrap to 0 after effective period-1.
REQ-016 At wrap with pend set, the active set SHALL be loaded from the shadow set, pend SHALL be cleared, and the new period SHALL start in the same wrap cycle; partial or runt periods are forbidden.
REQ-017 clk_out SHALL be registered and SHALL equal (cnt < H_a) in every enabled cycle: H_a=0 gives constant low, H_a>=period gives constant high.
REQ-018 tick[c] SHALL be 1 exactly in the cycles where cnt=0 and en[c]=1.
REQ-019 While en[c]=0, cnt, clk_out and tick SHALL be 0 from the next edge, and a pending shadow set SHALL be applied at that edge.
REQ-020 On the rising edge of en, the first enabled cycle SHALL have cnt=0, tick=1 and clk_out=(H_a>0).
REQ-021 If load and wrap occur in the same cycle, the old shadow set SHALL be applied and the new values SHALL stay pending.
REQ-022 Channels SHALL be fully independent; there is no phase alignment between channels.

Reset
REQ-023 With rst_n=0, all of the following SHALL be 0 asynchronously: cnt, clk_out, tick, pend, N_a, H_a, N_s and H_s.
REQ-024 Reset asserted mid-period SHALL abort the period immediately and discard pending settings; after release the next period SHALL start from cnt=0.

Structure
REQ-025 Package clk_div_pkg SHALL hold the default W, the minimum ratio constant (2), and the per-channel settings record type.
REQ-026 Sub-module clk_div_ch SHALL implement one channel and SHALL be instantiated CH times by a generate loop; the top SHALL contain only field slicing.

Verification
REQ-027 Case 1: rst_n released, load N=4 H=2, en=1. Required: clk_out = 1100 repeating, and tick once every 4 cycles.
REQ-028 Case 2: running at N=4 H=2, load N=6 H=3 at cnt=1. Required: pend=1 until wrap, the current 4-cycle period completes, then clk_out = 111000 repeating.
REQ-029 Case 3: settings N=1 H=1, then N=5 H=0, then N=5 H=7. Required: period 2 with pattern 10, then constant 0 with ticks every 5 cycles, then constant 1.
REQ-030 Case 4: load pulse in the wrap cycle. Required: the previous shadow set is applied, and the new values take effect one period later.
REQ-031 Case 5: deassert en, or pulse rst_n low, mid-period. Required: outputs 0 on the next edge (immediately for reset); on re-enable, tick=1 in the first cycle.
REQ-032 Case 6: CH=4 with distinct N per channel. Required: each channel's period is independent, with no cross-channel interference.
